// File: rtl/status_register_if.sv
// rtl/status_register_if.sv - status flag byte bus between the ALU/control path and the status register
//
// Purpose: carries the next flag byte toward the register and the stored flag
//          byte back to condition/branch logic.
// Signals:
//   SRSet  [WIDTH-1:0]  next status byte, driven by the master
//   SRData [WIDTH-1:0]  current registered status byte, driven by the slave
// Modports:
//   master  ALU/control side (drives SRSet, reads SRData)
//   slave   status register side (reads SRSet, drives SRData)
`timescale 1ns/1ps

interface status_register_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] SRSet;
    logic [WIDTH-1:0] SRData;

    modport master (
        output SRSet,
        input  SRData
    );

    modport slave (
        input  SRSet,
        output SRData
    );
endinterface

// File: rtl/status_register.sv
// rtl/status_register.sv - CPU status (flags) register, full overwrite every clock
//
// Purpose: holds the WIDTH-bit flag word. Every rising clk edge outside reset
//          copies SRSet into the register bit-for-bit; SRData is driven only
//          from the register, so there is no combinational SRSet->SRData path.
// Ports:
//   clk  input   system clock, rising-edge active
//   rst  input   asynchronous active-low reset (0 forces RESET_VALUE at once)
//   sr   slave   status bus: SRSet (next byte in), SRData (stored byte out)
`timescale 1ns/1ps

module status_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst,
    status_register_if.slave   sr
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // No enable or masking: the next state is always the full presented byte.
    assign sr_d = sr.SRSet;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= RESET_VALUE;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr.SRData = sr_q;

endmodule

// File: tb/tb_status_register.sv
// tb/tb_status_register.sv - directed self-checking bench for status_register
`timescale 1ns/1ps

module tb_status_register;

    logic clk;
    logic rst;
    logic clk_en;
    int   total;
    int   bad;

    status_register_if #(.WIDTH(8)) bus ();

    status_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sr  (bus.slave)
    );

    // Gated clock so the bench can hold clk idle low for the no-edge checks.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] expected);
        total++;
        assert (bus.SRData === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.SRData, expected);
        end
    endtask

    // Present a value mid-cycle, confirm it has not leaked through before the
    // edge, then confirm it appears right after the edge.
    task automatic step(input string tag, input logic [7:0] value, input logic [7:0] prev);
        @(negedge clk);
        bus.SRSet = value;
        #1;
        check({tag, "_pre"}, prev);
        @(posedge clk);
        #1;
        check(tag, value);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        clk_en    = 1'b1;
        rst       = 1'b0;
        bus.SRSet = 8'hA5;

        // Reset held across several rising edges: nothing loads.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 8'h00);
        end

        // Release away from the rising edge; first edge loads SRSet.
        @(negedge clk);
        rst       = 1'b1;
        bus.SRSet = 8'h01;
        #1;
        check("release_no_edge", 8'h00);
        @(posedge clk);
        #1;
        check("first_load", 8'h01);
        step("load_ff", 8'hFF, 8'h01);
        step("load_25", 8'h25, 8'hFF);

        // One value per clock, each visible exactly one edge later.
        step("seq_2a", 8'h2A, 8'h25);
        step("seq_b0", 8'hB0, 8'h2A);
        step("seq_df", 8'hDF, 8'hB0);
        step("seq_07", 8'h07, 8'hDF);
        step("seq_0b", 8'h0B, 8'h07);

        // Mid-cycle change of SRSet while holding 0xDF.
        step("hold_df", 8'hDF, 8'h0B);
        #1;
        bus.SRSet = 8'h07;
        @(negedge clk);
        #1;
        check("midcycle_hold", 8'hDF);
        @(posedge clk);
        #1;
        check("midcycle_load", 8'h07);

        // Asynchronous reset between edges while holding 0xFF.
        step("pre_reset_ff", 8'hFF, 8'h07);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 8'h00);
        bus.SRSet = 8'h0B;
        @(posedge clk);
        #1;
        check("reset_edge_no_load", 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_stale", 8'h00);
        @(posedge clk);
        #1;
        check("post_reset_load", 8'h0B);

        // Clock idle low with SRSet toggling: register must not move.
        @(negedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.SRSet = (i % 2 == 0) ? 8'h00 : 8'hFF;
            #7;
            check("idle_hold", 8'h0B);
        end
        bus.SRSet = 8'h3C;
        #3;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("idle_resume", 8'h3C);

        // Every byte value stores and reads back unchanged.
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            bus.SRSet = v[7:0];
            @(posedge clk);
            #1;
            check("all_values", v[7:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
